// File: rtl/rt_mem_reader.sv
// Sequential read-back engine for RT memory port B: reads N consecutive words,
// streams them on a valid/ready port and accumulates a wrapping 32-bit checksum.
module rt_mem_reader #(
  parameter int ADDR_WIDTH     = 22,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-3:0] num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [31:0]           checksum_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [2:0]            mem_lim_funct_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic [31:0]           rdata_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  rlast_o
);

  localparam int CW = ADDR_WIDTH - 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic [2:0]            state_r, next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [CW-1:0]         remain_r;
  logic [TW-1:0]         tmo_r;
  logic [31:0]           checksum_r, rdata_r;
  logic                  busy_r, done_r, error_r, en_r, rvalid_r, rlast_r;
  logic                  accept_s, capture_s, hs_s, timeout_s, last_s;

  assign last_s = (remain_r == CW'(1));

  // Next-state decode plus the one-cycle events that drive the datapath
  always_comb begin
    next_s    = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    hs_s      = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          accept_s = 1'b1;
          if (num_words_i == CW'(0)) next_s = ST_IDLE;
          else                       next_s = ST_REQ;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_REQ:  next_s = ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          capture_s = 1'b1;
          next_s    = ST_OUT;
        end else if (tmo_r == TMO_LAST) begin
          timeout_s = 1'b1;
          next_s    = ST_IDLE;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (rready_i) begin
          hs_s   = 1'b1;
          next_s = last_s ? ST_IDLE : ST_GAP;
        end else begin
          next_s = ST_OUT;
        end
      end
      ST_GAP:  next_s = ST_REQ;
      default: next_s = ST_IDLE;
    endcase
  end

  // Control state and registered status/strobe outputs, all derived from next_s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      en_r     <= 1'b0;
      rvalid_r <= 1'b0;
      rlast_r  <= 1'b0;
    end else begin
      state_r  <= next_s;
      busy_r   <= (next_s != ST_IDLE);
      en_r     <= (next_s == ST_REQ);
      rvalid_r <= (next_s == ST_OUT);
      rlast_r  <= (next_s == ST_OUT) && last_s;
      done_r   <= (accept_s && (num_words_i == CW'(0))) || timeout_s || (hs_s && last_s);
      if (accept_s)       error_r <= 1'b0;
      else if (timeout_s) error_r <= 1'b1;
      else                error_r <= error_r;
    end
  end

  // Address, word count, checksum, timeout counter and captured read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= {ADDR_WIDTH{1'b0}};
      remain_r   <= {CW{1'b0}};
      tmo_r      <= {TW{1'b0}};
      checksum_r <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
    end else begin
      if (accept_s)                addr_r <= base_addr_i & ~ADDR_WIDTH'(3);
      else if (state_r == ST_GAP)  addr_r <= addr_r + ADDR_WIDTH'(4);
      else                         addr_r <= addr_r;

      if (accept_s)  remain_r <= num_words_i;
      else if (hs_s) remain_r <= remain_r - CW'(1);
      else           remain_r <= remain_r;

      if (accept_s)  checksum_r <= 32'h0000_0000;
      else if (hs_s) checksum_r <= checksum_r + rdata_r;
      else           checksum_r <= checksum_r;

      if (state_r == ST_REQ)       tmo_r <= {TW{1'b0}};
      else if (state_r == ST_WAIT) tmo_r <= tmo_r + TW'(1);
      else                         tmo_r <= tmo_r;

      if (capture_s) rdata_r <= mem_rdata_i;
      else           rdata_r <= rdata_r;
    end
  end

  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign error_o         = error_r;
  assign checksum_o      = checksum_r;
  assign mem_en_o        = en_r;
  assign mem_we_o        = 1'b0;
  assign mem_be_o        = 4'b1111;
  assign mem_lim_funct_o = 3'b000;
  assign mem_addr_o      = addr_r;
  assign rdata_o         = rdata_r;
  assign rvalid_o        = rvalid_r;
  assign rlast_o         = rlast_r;

endmodule

// File: tb/tb_rt_mem_reader.sv
// Randomized bench for rt_mem_reader: a port-B memory model with configurable
// latency/failure, a stream monitor, and expectations computed from word lists.
module tb_rt_mem_reader;
  localparam int AW  = 22;
  localparam int TMO = 64;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n, start_i, mem_rvalid_i, rready_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-3:0] num_words_i;
  logic [31:0]   mem_rdata_i;
  logic          busy_o, done_o, error_o, mem_en_o, mem_we_o, rvalid_o, rlast_o;
  logic [31:0]   checksum_o, rdata_o;
  logic [3:0]    mem_be_o;
  logic [2:0]    mem_lim_funct_o;
  logic [AW-1:0] mem_addr_o;

  always #5 clk = ~clk;

  rt_mem_reader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .checksum_o(checksum_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_lim_funct_o(mem_lim_funct_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rlast_o(rlast_o)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [int];

  function automatic logic [31:0] memval(input int a);
    if (mem.exists(a)) return mem[a];
    return 32'(a) * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  // environment configuration and memory-model state
  int cfg_lat = 5, cfg_rmode = 0, cfg_fail_at = NEVER;
  bit cfg_spur = 1'b0;
  int req_idx = 0, rem = 0, bp_hold = 0;
  bit active = 1'b0;
  logic [AW-1:0] paddr;
  int lat_q[$];

  // monitor state
  logic [AW-1:0] en_q[$];
  int            en_cyc_q[$];
  logic [31:0]   st_q[$];
  bit            last_q[$];
  int            done_n = 0, done_cyc = 0, viol = 0;
  logic [31:0]   done_sum = 32'h0;
  logic          done_err = 1'b0, done_busy = 1'b0;
  logic          prev_en = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  logic [31:0]   prev_rd = 32'h0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model (responds rem cycles after an en) and rready driver
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    rready_i     = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && mem_en_o) begin : take_req
        int l;
        l = (cfg_lat == 0) ? int'($urandom_range(6, 1)) : cfg_lat;
        if (req_idx < cfg_fail_at) begin
          active = 1'b1;
          rem    = l;
          paddr  = mem_addr_o;
          lat_q.push_back(l);
        end
        req_idx++;
      end
      @(posedge clk);
      #1;
      mem_rvalid_i = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
      end else if (active) begin
        rem--;
        if (rem == 0) begin
          active       = 1'b0;
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = memval(int'(paddr));
        end
      end else if (cfg_spur && $urandom_range(3, 0) == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_0000 | 32'($urandom_range(65535, 0));
      end
      case (cfg_rmode)
        0:       rready_i = 1'b1;
        1:       rready_i = 1'($urandom_range(1, 0));
        default: begin
          if (rvalid_o && st_q.size() == 1 && bp_hold < 10) begin
            rready_i = 1'b0;
            bp_hold++;
          end else begin
            rready_i = 1'b1;
          end
        end
      endcase
    end
  end

  // stream/port monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (mem_en_o) begin
        en_q.push_back(mem_addr_o);
        en_cyc_q.push_back(cyc);
        if (prev_en || rvalid_o) viol++;
      end
      if (rvalid_o && prev_rv && !prev_rr && rdata_o != prev_rd) viol++;
      if (rlast_o && !rvalid_o) viol++;
      if (rvalid_o && rready_i) begin
        st_q.push_back(rdata_o);
        last_q.push_back(rlast_o);
      end
      if (done_o) begin
        done_n++;
        done_cyc  = cyc;
        done_sum  = checksum_o;
        done_err  = error_o;
        done_busy = busy_o;
      end
      prev_en = mem_en_o;
      prev_rv = rvalid_o;
      prev_rr = rready_i;
      prev_rd = rdata_o;
    end else begin
      prev_en = 1'b0;
      prev_rv = 1'b0;
    end
  end

  task automatic clear_mon();
    en_q.delete();
    en_cyc_q.delete();
    st_q.delete();
    last_q.delete();
    lat_q.delete();
    done_n  = 0;
    viol    = 0;
    req_idx = 0;
    bp_hold = 0;
  endtask

  task automatic run_txn(input string name, input logic [AW-1:0] base, input int n,
                         input int lat, input int rmode, input int fail_at,
                         input bit poke, input bit spur);
    int m, exp_en, start_c, k, exp_t, ea;
    bit err;
    logic [31:0] sum;
    @(posedge clk);
    #1;
    cfg_lat = lat; cfg_rmode = rmode; cfg_fail_at = fail_at; cfg_spur = spur;
    clear_mon();
    start_i     = 1'b1;
    base_addr_i = base;
    num_words_i = n[AW-3:0];
    start_c     = cyc;
    k = 0;
    while (done_n == 0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) start_i = 1'b0;
      if (poke && k == 2) begin
        start_i     = 1'b1;
        base_addr_i = 22'h2A_AAA8;
        num_words_i = 20'd7;
      end
      if (poke && k == 3) start_i = 1'b0;
    end
    if (done_n == 0) check_eq({name, "/done_wait"}, 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    m = (lat > TMO) ? 0 : fail_at;
    if (m > n) m = n;
    err    = (n > 0) && (m < n);
    exp_en = (n == 0) ? 0 : (err ? m + 1 : n);
    check_eq({name, "/done_pulses"}, 64'(done_n), 64'd1);
    check_eq({name, "/en_count"}, 64'(en_q.size()), 64'(exp_en));
    for (int i = 0; i < exp_en && i < en_q.size(); i++) begin
      ea = ((int'(base) & ~3) + 4 * i) % (1 << AW);
      check_eq({name, "/en_addr"}, 64'(en_q[i]), 64'(ea));
    end
    check_eq({name, "/word_count"}, 64'(st_q.size()), 64'(m));
    sum = 32'h0;
    for (int i = 0; i < m; i++) begin
      ea  = ((int'(base) & ~3) + 4 * i) % (1 << AW);
      sum = sum + memval(ea);
      if (i < st_q.size()) begin
        check_eq({name, "/word"}, 64'(st_q[i]), 64'(memval(ea)));
        check_eq({name, "/rlast"}, 64'(last_q[i]), 64'(i == n - 1));
      end
    end
    check_eq({name, "/checksum"}, 64'(done_sum), 64'(sum));
    check_eq({name, "/error"}, 64'(done_err), 64'(err));
    check_eq({name, "/busy_at_done"}, 64'(done_busy), 64'd0);
    check_eq({name, "/protocol"}, 64'(viol), 64'd0);
    if (n > 0 && en_cyc_q.size() > 0)
      check_eq({name, "/first_en_cycle"}, 64'(en_cyc_q[0] - start_c), 64'd1);
    if (n == 0) begin
      check_eq({name, "/done_cycle"}, 64'(done_cyc - start_c), 64'd1);
    end else if (err) begin
      if (en_cyc_q.size() == exp_en)
        check_eq({name, "/timeout_cycle"}, 64'(done_cyc - en_cyc_q[exp_en-1]), 64'(TMO + 1));
    end else if (rmode != 1 && lat_q.size() == n) begin
      exp_t = (rmode == 2 && n >= 2) ? 10 : 0;
      for (int i = 0; i < n; i++) exp_t += lat_q[i] + 3;
      check_eq({name, "/done_cycle"}, 64'(done_cyc - start_c), 64'(exp_t));
    end
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "/busy"}, 64'(busy_o), 64'd0);
    check_eq({name, "/done"}, 64'(done_o), 64'd0);
    check_eq({name, "/error"}, 64'(error_o), 64'd0);
    check_eq({name, "/checksum"}, 64'(checksum_o), 64'd0);
    check_eq({name, "/mem_en"}, 64'(mem_en_o), 64'd0);
    check_eq({name, "/mem_addr"}, 64'(mem_addr_o), 64'd0);
    check_eq({name, "/rvalid"}, 64'(rvalid_o), 64'd0);
    check_eq({name, "/rlast"}, 64'(rlast_o), 64'd0);
    check_eq({name, "/rdata"}, 64'(rdata_o), 64'd0);
    check_eq({name, "/mem_we"}, 64'(mem_we_o), 64'd0);
    check_eq({name, "/mem_be"}, 64'(mem_be_o), 64'hF);
    check_eq({name, "/lim_funct"}, 64'(mem_lim_funct_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    int n;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    num_words_i = '0;
    mem[32'h100]    = 32'h1111_1111;
    mem[32'h104]    = 32'h2222_2222;
    mem[32'h108]    = 32'h3333_3333;
    mem[32'h3FFFFC] = 32'hFFFF_FFFF;
    mem[32'h0]      = 32'h0000_0002;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset_idle");

    run_txn("basic", 22'h100, 3, 5, 0, NEVER, 1'b0, 1'b0);
    check_eq("basic/sum_const", 64'(done_sum), 64'h6666_6666);
    run_txn("backpressure", 22'h100, 3, 5, 2, NEVER, 1'b0, 1'b0);
    run_txn("zero_words", 22'h1234, 0, 5, 0, NEVER, 1'b0, 1'b0);
    run_txn("timeout", 22'h200, 2, 5, 0, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("timeout/error_sticky", 64'(error_o), 64'd1);
    run_txn("after_timeout", 22'h300, 1, 3, 0, NEVER, 1'b0, 1'b0);
    run_txn("partial_timeout", 22'h400, 3, 4, 0, 1, 1'b0, 1'b0);
    run_txn("lat_max", 22'h500, 1, TMO, 0, NEVER, 1'b0, 1'b0);
    run_txn("lat_over", 22'h504, 1, TMO + 1, 0, NEVER, 1'b0, 1'b0);
    run_txn("wrap", 22'h3F_FFFE, 2, 2, 0, NEVER, 1'b0, 1'b0);
    check_eq("wrap/sum_const", 64'(done_sum), 64'h1);
    run_txn("busy_start", 22'h600, 3, 4, 0, NEVER, 1'b1, 1'b0);

    // abort in the WAIT state of the second word
    @(posedge clk);
    #1;
    cfg_lat = 5; cfg_rmode = 0; cfg_fail_at = NEVER; cfg_spur = 1'b0;
    clear_mon();
    start_i     = 1'b1;
    base_addr_i = 22'h700;
    num_words_i = 20'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    k = 0;
    while (en_q.size() < 2 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("midrst/reached_wait", 64'(en_q.size()), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("midrst/no_done", 64'(done_n), 64'd0);
    run_txn("post_midrst", 22'h700, 3, 5, 0, NEVER, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(6, 0));
      run_txn("random", AW'($urandom), n, 0, int'($urandom_range(1, 0)), NEVER,
              (n > 0) && ($urandom_range(1, 0) == 1), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rt_mem_reader.md
# rt_mem_reader

Sequential read-back engine for the racetrack/LiM data memory port B. It reads `num_words_i` consecutive 32-bit words starting at a word-aligned byte address, using the port-B enable/valid protocol that the firmware loader uses for writes. It streams each word out on a valid/ready interface and accumulates a 32-bit checksum. It sits beside the RT memory in the wrapper and is used for post-load verification and memory dumps.

## Interface
- `ADDR_WIDTH`, 22, byte-address width of port B
- `TIMEOUT_CYCLES`, 64, maximum clk cycles to wait for `mem_rvalid_i` per word (must be >= 2)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  one-cycle start request; ignored while `busy_o`
- `base_addr_i`  in  ADDR_WIDTH  first byte address; bits [1:0] treated as 0
- `num_words_i`  in  ADDR_WIDTH-2  number of words to read
- `busy_o`  out  1  high from the cycle after accepted start until `done_o`
- `done_o`  out  1  one-cycle completion pulse
- `error_o`  out  1  sticky timeout flag; cleared by next accepted start
- `checksum_o`  out  32  sum mod 2^32 of all words handed out
- `mem_en_o`  out  1  port-B request strobe
- `mem_we_o`  out  1  constant 0
- `mem_be_o`  out  4  constant 4'b1111
- `mem_lim_funct_o`  out  3  constant 0 (no LiM op)
- `mem_addr_o`  out  ADDR_WIDTH  current byte address
- `mem_rdata_i`  in  32  port-B read data
- `mem_rvalid_i`  in  1  port-B read valid
- `rdata_o`  out  32  streamed word
- `rvalid_o`  out  1  stream valid
- `rready_i`  in  1  stream ready
- `rlast_o`  out  1  high with `rvalid_o` on the final word

## Operation
- States: IDLE, REQ, WAIT, OUT, GAP.
- IDLE, `start_i`=1: latch `base_addr_i & ~3` into addr, latch the count, clear checksum/error, set `busy_o`.
  - Count = 0: go straight to done (pulse `done_o` next cycle, no memory access).
  - Otherwise go to REQ.
- REQ: `mem_en_o`=1 for exactly one cycle, then go to WAIT; clear timeout counter.
- WAIT: `mem_en_o`=0.
  - First cycle with `mem_rvalid_i`=1: capture `mem_rdata_i` into `rdata_o`, go to OUT.
  - Timeout counter increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES` without rvalid: set `error_o`, pulse `done_o`, clear `busy_o`, go to IDLE. The checksum keeps its partial value.
- OUT: `rvalid_o`=1 and `rdata_o` held stable until `rready_i`=1.
  - On handshake: checksum += `rdata_o` (wrapping) and decrement remaining count.
  - Last word: pulse `done_o` next cycle and go to IDLE.
  - Otherwise go to GAP.
- GAP: one idle cycle. addr += 4 modulo 2^ADDR_WIDTH (wraps to 0), then go to REQ.
- `mem_rvalid_i` outside WAIT is ignored. `start_i` while busy is ignored.
- `mem_addr_o` is stable from REQ through GAP of each word.

## Timing
- Reset values: state IDLE; all outputs 0, including `mem_addr_o`, `checksum_o` and `error_o`. `mem_be_o` is 4'b1111.
- Reset mid-operation aborts immediately. `mem_en_o` and `rvalid_o` drop asynchronously and no `done_o` is produced.
- Start sampled at edge T0 → `mem_en_o` high T0+1 → WAIT from T0+2.
- rvalid seen at edge Tk → `rvalid_o` high in cycle Tk+1.
- With `rready_i` held at 1: handshake Tk+1, GAP Tk+2, next REQ Tk+3. Per-word cost = memory latency + 3 cycles.
- `done_o` asserts the cycle after the final handshake. `busy_o` falls in the same cycle. `checksum_o` is final when `done_o` is high.
- `rlast_o` = `rvalid_o` AND remaining count == 1.

## Test plan
- Preload words 0x11111111, 0x22222222, 0x33333333 at base 0x100, memory model rvalid 5 cycles after en, `num_words_i`=3, rready=1 → three single-cycle `mem_en_o` pulses at addrs 0x100/0x104/0x108, stream order preserved, `rlast_o` on word 3, `checksum_o`=0x66666666, one `done_o` pulse, `error_o`=0.
- Backpressure: rready low for 10 cycles on word 2 → `rdata_o` stable, no new `mem_en_o` until handshake, same checksum.
- `num_words_i`=0 → `done_o` one cycle after start, no `mem_en_o`, checksum 0.
- Memory never asserts rvalid, TIMEOUT_CYCLES=64 → `error_o`=1 and `done_o` exactly 64 WAIT cycles after the en pulse; next start clears `error_o`.
- Wrap: base 0x3FFFFC, 2 words, words 0xFFFFFFFF and 0x00000002 → addrs 0x3FFFFC then 0x000000, checksum 0x00000001.
- Assert rst_n low mid-WAIT → all outputs 0 immediately; a subsequent start runs cleanly. Start pulse while busy → no effect.
